// File: rtl/usi_buffer_pkg.sv
// Shared types and default sizing for the USI register-side/serial-side data buffer.
// Mode encoding matches the mode_sel register field; unlisted codes behave as normal.
package usi_buffer_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_LOOPBACK = 2'b01
    } buf_mode_e;

    localparam int DEFAULT_DEPTH      = 128;
    localparam int DEFAULT_WORD_BYTES = 4;

endpackage

// File: rtl/usi_byte_fifo.sv
// Circular byte FIFO with a multi-byte write port and a multi-byte show-ahead read port.
// The caller guarantees writes fit and reads do not exceed the count; flush wins over both.
module usi_byte_fifo
    import usi_buffer_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int AW         = $clog2(DEPTH),
    parameter int CW         = $clog2(DEPTH) + 1,
    parameter int BW         = $clog2(WORD_BYTES + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [8*WORD_BYTES-1:0] wr_data,
    input  logic [BW-1:0]           wr_bytes,
    input  logic                    rd_en,
    input  logic [BW-1:0]           rd_bytes,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic [BW-1:0]           rd_avail,
    output logic [CW-1:0]           count,
    output logic [CW-1:0]           free
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] WB_C    = CW'(WORD_BYTES);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] wr_inc;
    logic [CW-1:0] rd_dec;

    assign free     = DEPTH_C - count;
    assign rd_avail = (count >= WB_C) ? BW'(WORD_BYTES) : count[BW-1:0];
    assign wr_inc   = wr_en ? CW'(wr_bytes) : '0;
    assign rd_dec   = rd_en ? CW'(rd_bytes) : '0;

    // Bytes beyond the available count read as zero so the word side never sees stale data.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (BW'(i) < rd_avail) begin
                rd_data[8*i +: 8] = mem[rd_ptr + AW'(i)];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && !flush && !RST) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (BW'(i) < wr_bytes) begin
                    mem[wr_ptr + AW'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(wr_bytes);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(rd_bytes);
            end
            count <= count + wr_inc - rd_dec;
        end
    end

endmodule

// File: rtl/usi_data_buffer_p.sv
// RX/TX byte buffer between the USI word-side register map and the serial byte engines.
// Holds accept/reject decisions, loopback steering, sticky error flags and watermarks.
module usi_data_buffer_p
    import usi_buffer_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int CW         = $clog2(DEPTH) + 1,
    parameter int BW         = $clog2(WORD_BYTES + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clear,
    input  logic [1:0]              mode_sel,
    input  logic                    rx_byte_valid,
    input  logic [7:0]              rx_byte,
    output logic                    rx_byte_ready,
    input  logic                    rx_pop,
    output logic [8*WORD_BYTES-1:0] rx_word,
    output logic [BW-1:0]           rx_word_bytes,
    input  logic                    tx_push,
    input  logic [8*WORD_BYTES-1:0] tx_word,
    input  logic [BW-1:0]           tx_push_bytes,
    output logic                    tx_byte_valid,
    output logic [7:0]              tx_byte,
    input  logic                    tx_byte_ready,
    input  logic [CW-1:0]           rx_thresh,
    input  logic [CW-1:0]           tx_thresh,
    output logic [CW-1:0]           rx_count,
    output logic [CW-1:0]           tx_count,
    output logic [CW:0]             buffer_occupancy,
    output logic                    rx_level,
    output logic                    tx_low,
    output logic                    rx_overflow,
    output logic                    rx_underflow,
    output logic                    tx_overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                    lb_mode;
    logic                    rx_full;
    logic                    tx_xfer;
    logic                    rx_wr_en;
    logic [7:0]              rx_wr_byte;
    logic                    rx_rd_en;
    logic                    rx_ovf_set;
    logic                    rx_unf_set;
    logic                    tx_bytes_legal;
    logic                    tx_fits;
    logic                    tx_push_ok;
    logic                    tx_ovf_set;
    logic [CW-1:0]           tx_free;
    logic [CW-1:0]           rx_free_unused;
    logic [BW-1:0]           tx_avail_unused;
    logic [8*WORD_BYTES-1:0] tx_head_word;
    logic [8*WORD_BYTES-9:0] tx_head_unused;

    assign lb_mode       = (buf_mode_e'(mode_sel) == MODE_LOOPBACK);
    assign rx_full       = (rx_count == DEPTH_C);
    assign rx_byte_ready = !rx_full && !lb_mode;

    assign tx_byte_valid  = (tx_count != '0);
    assign tx_byte        = tx_head_word[7:0];
    assign tx_head_unused = tx_head_word[8*WORD_BYTES-1:8];
    assign tx_xfer        = tx_byte_valid && tx_byte_ready;

    // In loopback the RX write source is the departing TX byte; a full RX never stalls TX.
    always_comb begin
        rx_wr_en   = 1'b0;
        rx_wr_byte = '0;
        rx_ovf_set = 1'b0;
        if (lb_mode) begin
            if (tx_xfer) begin
                if (rx_full) begin
                    rx_ovf_set = 1'b1;
                end else begin
                    rx_wr_en   = 1'b1;
                    rx_wr_byte = tx_byte;
                end
            end
        end else if (rx_byte_valid) begin
            if (rx_full) begin
                rx_ovf_set = 1'b1;
            end else begin
                rx_wr_en   = 1'b1;
                rx_wr_byte = rx_byte;
            end
        end
    end

    assign rx_rd_en   = rx_pop && (rx_count != '0);
    assign rx_unf_set = rx_pop && (rx_count == '0);

    assign tx_bytes_legal = (tx_push_bytes != '0) && (tx_push_bytes <= BW'(WORD_BYTES));
    assign tx_fits        = (tx_free >= CW'(tx_push_bytes));
    assign tx_push_ok     = tx_push && tx_bytes_legal && tx_fits;
    assign tx_ovf_set     = tx_push && (tx_push_bytes != '0) && !tx_push_ok;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            rx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            if (rx_ovf_set) rx_overflow  <= 1'b1;
            if (rx_unf_set) rx_underflow <= 1'b1;
            if (tx_ovf_set) tx_overflow  <= 1'b1;
        end
    end

    assign rx_level         = (rx_count >= rx_thresh);
    assign tx_low           = (tx_count <= tx_thresh);
    assign buffer_occupancy = {1'b0, rx_count} + {1'b0, tx_count};

    usi_byte_fifo #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_rx_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (clear),
        .wr_en    (rx_wr_en),
        .wr_data  ({{(8*WORD_BYTES-8){1'b0}}, rx_wr_byte}),
        .wr_bytes (BW'(1)),
        .rd_en    (rx_rd_en),
        .rd_bytes (rx_word_bytes),
        .rd_data  (rx_word),
        .rd_avail (rx_word_bytes),
        .count    (rx_count),
        .free     (rx_free_unused)
    );

    usi_byte_fifo #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_tx_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (clear),
        .wr_en    (tx_push_ok),
        .wr_data  (tx_word),
        .wr_bytes (tx_push_bytes),
        .rd_en    (tx_xfer),
        .rd_bytes (BW'(1)),
        .rd_data  (tx_head_word),
        .rd_avail (tx_avail_unused),
        .count    (tx_count),
        .free     (tx_free)
    );

endmodule
